hilo_muldiv_unit: RTL and testbench



---
 rtl/hilo_muldiv_unit_if.sv | 25 ++
 rtl/hilo_muldiv_unit.sv | 125 ++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// Execute-stage bundle between the pipeline and the HI/LO multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface hilo_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       aluopE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic             flushE;
    logic             stallE;
    logic             stall_divE;
    logic [WIDTH-1:0] hilo_resultE;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output aluopE, srcaE, srcbE, flushE, stallE,
        input  stall_divE, hilo_resultE, hi_o, lo_o
    );

    modport slave (
        input  aluopE, srcaE, srcbE, flushE, stallE,
        output stall_divE, hilo_resultE, hi_o, lo_o
    );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO owner: single-cycle MULT/MULTU, MT/MF moves, and a radix-2 restoring divider.
// A divide holds stall_divE for issue + WIDTH busy cycles; flushE cancels anything in flight.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    hilo_muldiv_unit_if.slave bus
);
    localparam logic [7:0] EXE_MFHI_OP  = 8'b0001_0000;
    localparam logic [7:0] EXE_MTHI_OP  = 8'b0001_0001;
    localparam logic [7:0] EXE_MFLO_OP  = 8'b0001_0010;
    localparam logic [7:0] EXE_MTLO_OP  = 8'b0001_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;
    logic [WIDTH-1:0]     divisor_q;
    logic [2*WIDTH-1:0]   work_q;
    logic [CW-1:0]        cnt_q;
    logic                 quo_neg_q;
    logic                 rem_neg_q;

    logic is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo, is_divop;
    assign is_mult  = (bus.aluopE == EXE_MULT_OP);
    assign is_multu = (bus.aluopE == EXE_MULTU_OP);
    assign is_div   = (bus.aluopE == EXE_DIV_OP);
    assign is_divu  = (bus.aluopE == EXE_DIVU_OP);
    assign is_mthi  = (bus.aluopE == EXE_MTHI_OP);
    assign is_mtlo  = (bus.aluopE == EXE_MTLO_OP);
    assign is_divop = is_div | is_divu;

    // Sign-extending both operands to 2*WIDTH makes the low 2*WIDTH bits of an
    // unsigned multiply equal to the signed product.
    logic [2*WIDTH-1:0] mul_a, mul_b, prod_d;
    assign mul_a  = is_multu ? {{WIDTH{1'b0}}, bus.srcaE} : {{WIDTH{bus.srcaE[WIDTH-1]}}, bus.srcaE};
    assign mul_b  = is_multu ? {{WIDTH{1'b0}}, bus.srcbE} : {{WIDTH{bus.srcbE[WIDTH-1]}}, bus.srcbE};
    assign prod_d = mul_a * mul_b;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    assign a_neg = is_div & bus.srcaE[WIDTH-1];
    assign b_neg = is_div & bus.srcbE[WIDTH-1];
    assign a_mag = a_neg ? -bus.srcaE : bus.srcaE;
    assign b_mag = b_neg ? -bus.srcbE : bus.srcbE;

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor from
    // the WIDTH+1-bit partial remainder, keep it if it did not go negative.
    logic [WIDTH:0]       partial, diff;
    logic                 fits;
    logic [2*WIDTH-1:0]   work_d;
    logic [WIDTH-1:0]     quo_d, rem_d;
    assign partial = work_q[2*WIDTH-1:WIDTH-1];
    assign diff    = partial - {1'b0, divisor_q};
    assign fits    = ~diff[WIDTH];
    assign work_d  = {(fits ? diff[WIDTH-1:0] : partial[WIDTH-1:0]), work_q[WIDTH-2:0], fits};
    assign quo_d   = quo_neg_q ? -work_d[WIDTH-1:0] : work_d[WIDTH-1:0];
    assign rem_d   = rem_neg_q ? -work_d[2*WIDTH-1:WIDTH] : work_d[2*WIDTH-1:WIDTH];

    assign bus.stall_divE   = ~bus.flushE & ((state_q == BUSY) | ((state_q == IDLE) & is_divop));
    assign bus.hilo_resultE = (bus.aluopE == EXE_MFHI_OP) ? hi_q :
                              (bus.aluopE == EXE_MFLO_OP) ? lo_q : '0;
    assign bus.hi_o = hi_q;
    assign bus.lo_o = lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            divisor_q <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else if (bus.flushE) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_divop) begin
                        quo_neg_q <= a_neg ^ b_neg;
                        rem_neg_q <= a_neg;
                        work_q    <= {{WIDTH{1'b0}}, a_mag};
                        divisor_q <= b_mag;
                        cnt_q     <= '0;
                        // Divide by zero leaves HI/LO alone and stalls only the issue cycle.
                        state_q   <= (bus.srcbE == '0) ? DONE : BUSY;
                    end else if (is_mult | is_multu) begin
                        hi_q <= prod_d[2*WIDTH-1:WIDTH];
                        lo_q <= prod_d[WIDTH-1:0];
                    end else if (is_mthi) begin
                        hi_q <= bus.srcaE;
                    end else if (is_mtlo) begin
                        lo_q <= bus.srcaE;
                    end
                end
                BUSY: begin
                    work_q <= work_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        hi_q    <= rem_d;
                        lo_q    <= quo_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // The divide op is still in E while stalled elsewhere; do not relaunch it.
                    if (!bus.stallE) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
module tb_hilo_muldiv_unit;
    localparam int W = 32;
    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] OP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] OP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] OP_MTLO  = 8'b0001_0011;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hilo_muldiv_unit_if #(.WIDTH(W)) bus ();
    hilo_muldiv_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural HI/LO plus how many divide cycles remain.
    logic [31:0] m_hi = '0, m_lo = '0, m_rhi = '0, m_rlo = '0;
    int          m_left = 0;
    bit          m_done = 1'b0;
    logic        exp_stall;
    logic [31:0] exp_res;

    task automatic ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
        int sa, sb;
        if (sgn) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = 32'h8000_0000;
                r = 32'h0;
            end else begin
                sa = $signed(a);
                sb = $signed(b);
                q  = sa / sb;
                r  = sa % sb;
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else if (bus.flushE) begin
            m_left = 0; m_done = 1'b0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_rhi; m_lo = m_rlo; m_done = 1'b1;
            end
        end else if (m_done) begin
            if (!bus.stallE) m_done = 1'b0;
        end else begin
            case (bus.aluopE)
                OP_MULT:  {m_hi, m_lo} = longint'($signed(bus.srcaE)) * longint'($signed(bus.srcbE));
                OP_MULTU: {m_hi, m_lo} = {32'h0, bus.srcaE} * {32'h0, bus.srcbE};
                OP_MTHI:  m_hi = bus.srcaE;
                OP_MTLO:  m_lo = bus.srcaE;
                OP_DIV, OP_DIVU: begin
                    if (bus.srcbE == 32'h0) begin
                        m_done = 1'b1;
                    end else begin
                        ref_div(bus.aluopE == OP_DIV, bus.srcaE, bus.srcbE, m_rlo, m_rhi);
                        m_left = 32;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_stall = !bus.flushE && (m_left > 0 ||
                        (!m_done && (bus.aluopE == OP_DIV || bus.aluopE == OP_DIVU)));
            exp_res   = (bus.aluopE == OP_MFHI) ? m_hi : (bus.aluopE == OP_MFLO) ? m_lo : 32'h0;
            check("model_hi", bus.hi_o, m_hi);
            check("model_lo", bus.lo_o, m_lo);
            check("model_stall", {31'h0, bus.stall_divE}, {31'h0, exp_stall});
            check("model_hilo_result", bus.hilo_resultE, exp_res);
        end
    end

    task automatic step(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fl, input logic st);
        @(posedge clk);
        #1;
        bus.aluopE = op; bus.srcaE = a; bus.srcbE = b; bus.flushE = fl; bus.stallE = st;
    endtask

    // Issues a divide, holds it while stalled, returns in the first non-stall cycle.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic st, output int cnt);
        cnt = 0;
        step(op, a, b, 1'b0, st);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.stall_divE) cnt++;
            else break;
        end
    endtask

    int n;

    initial begin
        bus.aluopE = OP_NOP; bus.srcaE = '0; bus.srcbE = '0; bus.flushE = 1'b0; bus.stallE = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_hi", bus.hi_o, 32'h0);
        check("reset_lo", bus.lo_o, 32'h0);
        check("reset_stall", {31'h0, bus.stall_divE}, 32'h0);
        check("reset_result", bus.hilo_resultE, 32'h0);

        step(OP_MULT, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
        step(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("mult_hi", bus.hi_o, 32'hFFFF_FFFF);
        check("mult_lo", bus.lo_o, 32'hFFFF_FFFE);

        step(OP_MULTU, 32'hFFFF_FFFF, 32'h2, 1'b0, 1'b0);
        step(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("multu_hi", bus.hi_o, 32'h0000_0001);
        check("multu_lo", bus.lo_o, 32'hFFFF_FFFE);

        run_div(OP_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, n);
        check("div_m7_2_stall_cycles", 32'(n), 32'd33);
        step(OP_MFLO, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("div_m7_2_mflo", bus.hilo_resultE, 32'hFFFF_FFFD);
        check("div_m7_2_hi", bus.hi_o, 32'hFFFF_FFFF);

        run_div(OP_DIVU, 32'hFFFF_FFFF, 32'h10, 1'b0, n);
        step(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("divu_lo", bus.lo_o, 32'h0FFF_FFFF);
        check("divu_hi", bus.hi_o, 32'h0000_000F);

        run_div(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n);
        step(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("div_ovf_lo", bus.lo_o, 32'h8000_0000);
        check("div_ovf_hi", bus.hi_o, 32'h0);

        run_div(OP_DIV, 32'h5, 32'h0, 1'b0, n);
        check("div0_stall_cycles", 32'(n), 32'd1);
        step(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("div0_lo", bus.lo_o, 32'h8000_0000);
        check("div0_hi", bus.hi_o, 32'h0);

        step(OP_MTHI, 32'hAAAA, 32'h0, 1'b0, 1'b0);
        step(OP_MTLO, 32'h5555, 32'h0, 1'b0, 1'b0);
        step(OP_DIV, 32'd100, 32'd3, 1'b0, 1'b0);
        repeat (9) step(OP_DIV, 32'd100, 32'd3, 1'b0, 1'b0);
        step(OP_DIV, 32'd100, 32'd3, 1'b1, 1'b0);
        @(negedge clk);
        check("flush_stall", {31'h0, bus.stall_divE}, 32'h0);
        step(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("flush_hi", bus.hi_o, 32'hAAAA);
        check("flush_lo", bus.lo_o, 32'h5555);
        run_div(OP_DIVU, 32'd100, 32'd3, 1'b0, n);
        check("after_flush_stall_cycles", 32'(n), 32'd33);
        step(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("after_flush_lo", bus.lo_o, 32'd33);
        check("after_flush_hi", bus.hi_o, 32'd1);

        run_div(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b1, n);
        check("held_div_stall_cycles", 32'(n), 32'd33);
        step(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1);
        @(negedge clk);
        check("held_done_stall_a", {31'h0, bus.stall_divE}, 32'h0);
        step(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1);
        @(negedge clk);
        check("held_done_stall_b", {31'h0, bus.stall_divE}, 32'h0);
        step(OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0, 1'b0);
        step(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        step(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("held_no_relaunch", {31'h0, bus.stall_divE}, 32'h0);
        check("held_lo", bus.lo_o, 32'hFFFF_FFF2);
        check("held_hi", bus.hi_o, 32'hFFFF_FFFE);

        step(OP_MTHI, 32'h1234, 32'h0, 1'b0, 1'b0);
        step(OP_MFHI, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        check("mthi_mfhi", bus.hilo_resultE, 32'h1234);

        step(OP_DIV, 32'd1000, 32'd3, 1'b0, 1'b0);
        repeat (5) step(OP_DIV, 32'd1000, 32'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.aluopE = OP_NOP;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_hi", bus.hi_o, 32'h0);
        check("midrst_lo", bus.lo_o, 32'h0);
        check("midrst_stall", {31'h0, bus.stall_divE}, 32'h0);
        repeat (3) step(OP_NOP, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
